counter_ctrl: RTL and testbench

COUNTER_CTRL -- requirements
Module: counter_ctrl

---
 rtl/counter_ctrl.sv | 117 +++++++++++
 tb/tb_counter_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_ctrl.sv
// counter_ctrl: start/hold/abort controlled up-counter with a clock prescaler.
// Counts from 0 up to a terminal value latched at start, then pulses done for
// one cycle. Optional build macro COUNTER_CTRL_AUTORELOAD_EN adds a reload_en
// input that lets DONE restart the sequence directly instead of going idle.
module counter_ctrl #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hold,
  input  logic             abort,
  input  logic [WIDTH-1:0] load_val,
`ifdef COUNTER_CTRL_AUTORELOAD_EN
  input  logic             reload_en,
`endif
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  // Prescaler only needs to hold 0..PRESCALE-1; keep at least one bit.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tick;
  logic             reload;
  logic             load_req;
  logic [WIDTH-1:0] count_inc;

  assign tick      = (pre_q == PRE_LAST);
  assign count_inc = count_q + WIDTH'(1);

`ifdef COUNTER_CTRL_AUTORELOAD_EN
  assign reload = reload_en;
`else
  assign reload = 1'b0;
`endif

  // A new sequence is armed either by start in IDLE or by auto-reload in DONE.
  assign load_req = ((state_q == IDLE) && start) || ((state_q == DONE) && reload);

  // Next-state and next-datapath logic; HOLD with hold released behaves as a
  // RUN cycle so the frozen prescaler resumes advancing immediately.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    term_d  = term_q;
    pre_d   = pre_q;
    if (load_req) begin
      term_d  = load_val;
      count_d = '0;
      pre_d   = '0;
      state_d = (load_val == '0) ? DONE : RUN;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        RUN, HOLD: begin
          if (abort) begin
            state_d = IDLE;
            count_d = '0;
            pre_d   = '0;
          end else if (hold) begin
            state_d = HOLD;
          end else begin
            state_d = RUN;
            if (tick) begin
              pre_d   = '0;
              count_d = count_inc;
              if (count_inc == term_q) begin
                state_d = DONE;
              end
            end else begin
              pre_d = pre_q + PW'(1);
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      term_q  <= '0;
      pre_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      term_q  <= term_d;
      pre_q   <= pre_d;
    end
  end

  assign count = count_q;
  assign state = state_q;
  assign busy  = (state_q == RUN) || (state_q == HOLD);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: drives two counter_ctrl instances (PRESCALE=1 and 3) with
// the same inputs and compares them against an elapsed-cycle reference model.
module tb_counter_ctrl;

  logic       clk;
  logic       rst, start, hold, abort, reloadEn;
  logic [3:0] loadVal;
  logic [3:0] count1, count3;
  logic       busy1, busy3, done1, done3;
  logic [1:0] state1, state3;

  int vectors;
  int miscompares;

  // Reference model: per instance, the number of active (non-held) run cycles
  // since start; count is that divided by the prescale factor.
  int mState[2];
  int mTerm[2];
  int mAct[2];
  int mCount[2];
  int autoReload;

  counter_ctrl #(.WIDTH(4), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .abort(abort),
    .load_val(loadVal),
`ifdef COUNTER_CTRL_AUTORELOAD_EN
    .reload_en(reloadEn),
`endif
    .count(count1), .busy(busy1), .done(done1), .state(state1)
  );

  counter_ctrl #(.WIDTH(4), .PRESCALE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .abort(abort),
    .load_val(loadVal),
`ifdef COUNTER_CTRL_AUTORELOAD_EN
    .reload_en(reloadEn),
`endif
    .count(count3), .busy(busy3), .done(done3), .state(state3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int preOf(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic checkOutput(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelLoad(input int i, input int lv);
    mTerm[i]  = lv;
    mAct[i]   = 0;
    mCount[i] = 0;
    mState[i] = (lv == 0) ? 3 : 1;
  endtask

  task automatic modelStep(input int r, input int s, input int h, input int a,
                           input int lv, input int re);
    for (int i = 0; i < 2; i++) begin
      if (r != 0) begin
        mState[i] = 0; mCount[i] = 0; mTerm[i] = 0; mAct[i] = 0;
      end else begin
        case (mState[i])
          0: if (s != 0) modelLoad(i, lv);
          1, 2: begin
            if (a != 0) begin
              mState[i] = 0;
              mCount[i] = 0;
            end else if (h != 0) begin
              mState[i] = 2;
            end else begin
              mAct[i]++;
              mCount[i] = mAct[i] / preOf(i);
              mState[i] = (mAct[i] == preOf(i) * mTerm[i]) ? 3 : 1;
            end
          end
          default: begin
            if (re != 0 && autoReload != 0) modelLoad(i, lv);
            else mState[i] = 0;
          end
        endcase
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("p1_state", int'(state1), mState[0]);
    checkOutput("p1_count", int'(count1), mCount[0]);
    checkOutput("p1_busy",  int'(busy1),  (mState[0] == 1 || mState[0] == 2) ? 1 : 0);
    checkOutput("p1_done",  int'(done1),  (mState[0] == 3) ? 1 : 0);
    checkOutput("p3_state", int'(state3), mState[1]);
    checkOutput("p3_count", int'(count3), mCount[1]);
    checkOutput("p3_busy",  int'(busy3),  (mState[1] == 1 || mState[1] == 2) ? 1 : 0);
    checkOutput("p3_done",  int'(done3),  (mState[1] == 3) ? 1 : 0);
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check at negedge.
  task automatic applyStimulus(input int r, input int s, input int h, input int a,
                               input int lv, input int re);
    rst      = (r != 0);
    start    = (s != 0);
    hold     = (h != 0);
    abort    = (a != 0);
    loadVal  = 4'(lv);
    reloadEn = (re != 0);
    @(posedge clk);
    modelStep(r, s, h, a, lv, re);
    @(negedge clk);
    checkAll();
  endtask

  initial begin
    int exp28[7];
    int doneCyc;
    int sawDone;
    vectors     = 0;
    miscompares = 0;
`ifdef COUNTER_CTRL_AUTORELOAD_EN
    autoReload = 1;
`else
    autoReload = 0;
`endif
    for (int i = 0; i < 2; i++) begin
      mState[i] = 0; mCount[i] = 0; mTerm[i] = 0; mAct[i] = 0;
    end
    exp28 = '{0, 1, 2, 3, 4, 5, 5};

    // Reset state.
    applyStimulus(1, 1, 1, 0, 9, 0);
    checkOutput("rst_state", int'(state1), 0);
    checkOutput("rst_count", int'(count1), 0);

    // Basic count to 5 with PRESCALE=1.
    applyStimulus(0, 1, 0, 0, 5, 0);
    for (int k = 0; k < 7; k++) begin
      if (k > 0) applyStimulus(0, 0, 0, 0, 5, 0);
      checkOutput("r28_count", int'(count1), exp28[k]);
      checkOutput("r28_done", int'(done1), (k == 5) ? 1 : 0);
    end
    checkOutput("r28_idle", int'(state1), 0);

    // Hold during cycles 3..5 delays done to cycle 9.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 5, 0);
    doneCyc = -1;
    for (int c = 1; c <= 11; c++) begin
      applyStimulus(0, 0, (c >= 3 && c <= 5) ? 1 : 0, 0, 5, 0);
      if (c + 1 >= 4 && c + 1 <= 6) begin
        checkOutput("r29_hold_state", int'(state1), 2);
        checkOutput("r29_hold_count", int'(count1), 2);
      end
      if (done1 && doneCyc < 0) doneCyc = c + 1;
    end
    checkOutput("r29_done_cycle", doneCyc, 9);

    // Abort at cycle 4.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 5, 0);
    sawDone = 0;
    for (int c = 1; c <= 8; c++) begin
      applyStimulus(0, 0, 0, (c == 4) ? 1 : 0, 5, 0);
      if (done1) sawDone = 1;
      if (c + 1 == 5) begin
        checkOutput("r30_state", int'(state1), 0);
        checkOutput("r30_count", int'(count1), 0);
        checkOutput("r30_busy", int'(busy1), 0);
      end
    end
    checkOutput("r30_no_done", sawDone, 0);

    // Zero terminal goes straight to DONE.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("r31_state", int'(state1), 3);
    checkOutput("r31_done", int'(done1), 1);
    checkOutput("r31_count", int'(count1), 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("r31_idle", int'(state1), 0);

    // PRESCALE=3, terminal 15: done at cycle 46.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 15, 0);
    doneCyc = -1;
    for (int c = 1; c <= 59; c++) begin
      applyStimulus(0, 0, 0, 0, 15, 0);
      if (done3 && doneCyc < 0) begin
        doneCyc = c + 1;
        checkOutput("r32_count", int'(count3), 15);
      end
    end
    checkOutput("r32_done_cycle", doneCyc, 46);

    // Reload request with terminal 2, then reset mid-run.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 2, 1);
    for (int c = 1; c <= 10; c++) applyStimulus(0, 0, 0, 0, 2, 1);
    applyStimulus(1, 0, 0, 0, 2, 1);
    checkOutput("r33_rst_state", int'(state3), 0);
    checkOutput("r33_rst_count", int'(count3), 0);
    checkOutput("r33_rst_busy", int'(busy3), 0);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      applyStimulus(($urandom_range(0, 99) == 0) ? 1 : 0,
                    ($urandom_range(0, 3) == 0) ? 1 : 0,
                    ($urandom_range(0, 4) == 0) ? 1 : 0,
                    ($urandom_range(0, 29) == 0) ? 1 : 0,
                    int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
